extend_imm_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational immediate extender. It widens the immediate to XLEN (32 or 64) and adds CSR-zimm and shift-amount types. It flags illegal selectors and carries a sideband tag. It sits between decode and execute behind a valid/ready interface with a 2-entry skid buffer, giving full throughput with a fully registered output.

---
 rtl/extend_imm_pipe.sv | 169 ++++++++++++++++
 tb/tb_extend_imm_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/extend_imm_pipe.sv
// Pipelined immediate extender: XLEN-wide immediates behind valid/ready with a 2-entry skid buffer.
// Optional illegal-request counter enabled by defining EXTIMM_ILLEGAL_CNT_EN.
module extend_imm_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [2:0]       in_immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_immext,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [15:0]      illegal_cnt
);

    // State is {out_valid, skid_valid}.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    // Argument is indexed with the instruction's own bit numbers [31:7].
    function automatic logic [XLEN-1:0] ext_imm(input logic [31:7] i, input logic [2:0] sel);
        logic [XLEN-1:0] r;
        r = '0;
        case (sel)
            3'b000:  r = XLEN'($signed(i[31:20]));
            3'b001:  r = XLEN'($signed({i[31:25], i[11:7]}));
            3'b010:  r = XLEN'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            3'b011:  r = XLEN'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            3'b100:  r = XLEN'($signed({i[31:12], 12'h000}));
            3'b101:  r = XLEN'(i[19:15]);
            3'b110:  r = (XLEN == 64) ? XLEN'(i[25:20]) : XLEN'(i[24:20]);
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic             accept_s;
    logic             drain_s;
    logic             in_ready_s;
    logic             load_out_s;
    logic             load_skid_s;
    logic             skid_to_out_s;
    logic [XLEN-1:0]  new_imm_s;
    logic             new_ill_s;
    logic [XLEN-1:0]  out_imm_r;
    logic [TAG_W-1:0] out_tag_r;
    logic             out_ill_r;
    logic [XLEN-1:0]  skid_imm_r;
    logic [TAG_W-1:0] skid_tag_r;
    logic             skid_ill_r;

    assign new_imm_s = ext_imm(in_instr, in_immsrc);
    assign new_ill_s = (in_immsrc == 3'b111);
    assign accept_s  = in_valid & in_ready_s;
    assign drain_s   = state_r[1] & out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and datapath load selects.
    always_comb begin
        state_nxt_s   = state_r;
        load_out_s    = 1'b0;
        load_skid_s   = 1'b0;
        skid_to_out_s = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_nxt_s = ST_ONE;
                    load_out_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && drain_s) begin
                    load_out_s = 1'b1;
                end else if (accept_s) begin
                    state_nxt_s = ST_FULL;
                    load_skid_s = 1'b1;
                end else if (drain_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_ONE;
                end
            end
            ST_FULL: begin
                if (drain_s) begin
                    state_nxt_s   = ST_ONE;
                    skid_to_out_s = 1'b1;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: state_nxt_s = ST_EMPTY;
        endcase
    end

    // Handshake outputs come straight from the state register (and reset), never from out_ready.
    always_comb begin
        in_ready_s = ~state_r[0] & ~reset;
        out_valid  = state_r[1];
        in_ready   = in_ready_s;
    end

    // Output and skid data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_imm_r  <= '0;
            out_tag_r  <= '0;
            out_ill_r  <= 1'b0;
            skid_imm_r <= '0;
            skid_tag_r <= '0;
            skid_ill_r <= 1'b0;
        end else begin
            if (load_out_s) begin
                out_imm_r <= new_imm_s;
                out_tag_r <= in_tag;
                out_ill_r <= new_ill_s;
            end else if (skid_to_out_s) begin
                out_imm_r <= skid_imm_r;
                out_tag_r <= skid_tag_r;
                out_ill_r <= skid_ill_r;
            end
            if (load_skid_s) begin
                skid_imm_r <= new_imm_s;
                skid_tag_r <= in_tag;
                skid_ill_r <= new_ill_s;
            end
        end
    end

    assign out_immext  = out_imm_r;
    assign out_tag     = out_tag_r;
    assign out_illegal = out_ill_r;

`ifdef EXTIMM_ILLEGAL_CNT_EN
    logic [15:0] ill_cnt_r;

    // Saturating count of accepted illegal requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            ill_cnt_r <= 16'h0000;
        end else if (accept_s && new_ill_s && (ill_cnt_r != 16'hFFFF)) begin
            ill_cnt_r <= ill_cnt_r + 16'h0001;
        end
    end

    assign illegal_cnt = ill_cnt_r;
`else
    assign illegal_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_extend_imm_pipe.sv
// Randomized self-checking bench for extend_imm_pipe: XLEN=32 and XLEN=64 instances share stimulus
// and are compared each cycle against a queue-based reference model.
module tb_extend_imm_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [24:0] in_instr;
    logic [2:0]  in_immsrc;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        rdy32, vld32, ill32, rdy64, vld64, ill64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [7:0]  tag32, tag64;
    logic [15:0] cnt32, cnt64;

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint unsigned i32;
        longint unsigned i64;
        logic [7:0]      tag;
        logic            ill;
    } exp_t;

    exp_t        q[$];
    logic [15:0] cnt_m = 16'h0000;

    always #5 clk = ~clk;

    extend_imm_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
        .out_valid(vld32), .out_ready(out_ready), .out_immext(imm32),
        .out_tag(tag32), .out_illegal(ill32), .illegal_cnt(cnt32));

    extend_imm_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
        .out_valid(vld64), .out_ready(out_ready), .out_immext(imm64),
        .out_tag(tag64), .out_illegal(ill64), .illegal_cnt(cnt64));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sext(input longint x, input int n);
        if (((x >> (n - 1)) & 64'd1) != 64'd0) return x - (64'sd1 <<< n);
        return x;
    endfunction

    // Reference extension from the field layouts, using plain shifts and masks.
    function automatic longint unsigned ref_imm(input logic [31:0] word, input logic [2:0] sel, input int xlen);
        longint w, v;
        w = longint'({32'h0, word});
        case (sel)
            3'd0:    v = sext(w >> 20, 12);
            3'd1:    v = sext(((w >> 25) << 5) | ((w >> 7) & 31), 12);
            3'd2:    v = sext((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11)
                              | (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1), 13);
            3'd3:    v = sext((((w >> 31) & 1) << 20) | (((w >> 12) & 255) << 12)
                              | (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1), 21);
            3'd4:    v = sext(w & 64'hFFFF_F000, 32);
            3'd5:    v = (w >> 15) & 31;
            3'd6:    v = (w >> 20) & ((xlen == 64) ? 63 : 31);
            default: v = 0;
        endcase
        if (xlen == 32) v = v & 64'hFFFF_FFFF;
        return longint'(v);
    endfunction

    // Model update on the active edge: drain the head, then append an accepted request.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            cnt_m = 16'h0000;
        end else begin
            bit acc;
            exp_t e;
            acc = in_valid && (q.size() < 2);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) begin
                e.i32 = ref_imm({in_instr, 7'h00}, in_immsrc, 32);
                e.i64 = ref_imm({in_instr, 7'h00}, in_immsrc, 64);
                e.tag = in_tag;
                e.ill = (in_immsrc == 3'd7);
                q.push_back(e);
`ifdef EXTIMM_ILLEGAL_CNT_EN
                if (e.ill && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
`endif
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic exp_rdy;
        exp_rdy = (q.size() < 2) && !reset;
        chk("in_ready32", {63'd0, rdy32}, {63'd0, exp_rdy});
        chk("in_ready64", {63'd0, rdy64}, {63'd0, exp_rdy});
        chk("out_valid32", {63'd0, vld32}, {63'd0, q.size() > 0});
        chk("out_valid64", {63'd0, vld64}, {63'd0, q.size() > 0});
        chk("illegal_cnt32", {48'd0, cnt32}, {48'd0, cnt_m});
        chk("illegal_cnt64", {48'd0, cnt64}, {48'd0, cnt_m});
        if (q.size() > 0) begin
            chk("immext32", {32'd0, imm32}, q[0].i32);
            chk("immext64", imm64, q[0].i64);
            chk("tag32", {56'd0, tag32}, {56'd0, q[0].tag});
            chk("tag64", {56'd0, tag64}, {56'd0, q[0].tag});
            chk("illegal32", {63'd0, ill32}, {63'd0, q[0].ill});
            chk("illegal64", {63'd0, ill64}, {63'd0, q[0].ill});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] word, input logic [2:0] sel, input logic [7:0] tag);
        in_valid  = 1'b1;
        in_instr  = word[31:7];
        in_immsrc = sel;
        in_tag    = tag;
    endtask

    // Single request into an empty pipe, then look at the result one cycle later.
    task automatic send1(input logic [31:0] word, input logic [2:0] sel, input logic [7:0] tag);
        drive(word, sel, tag);
        step();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_immsrc = '0; in_tag = '0; out_ready = 1'b1;

        // Pin the reference model with hand-computed values.
        chk("model_I", ref_imm(32'hFFF00093, 3'd0, 32), 64'hFFFF_FFFF);
        chk("model_B", ref_imm(32'hFE000EE3, 3'd2, 32), 64'hFFFF_FFFC);
        chk("model_U", ref_imm(32'h123450B7, 3'd4, 32), 64'h1234_5000);
        chk("model_LUI64", ref_imm(32'h800000B7, 3'd4, 64), 64'hFFFF_FFFF_8000_0000);
        chk("model_SH64", ref_imm(32'h03F00000, 3'd6, 64), 64'd63);
        chk("model_SH32", ref_imm(32'h03F00000, 3'd6, 32), 64'd31);

        step();
        @(negedge clk);
        chk("rst_out_valid", {63'd0, vld32}, 64'd0);
        chk("rst_immext", imm64, 64'd0);
        chk("rst_tag", {56'd0, tag32}, 64'd0);
        chk("rst_illegal", {63'd0, ill32}, 64'd0);
        chk("rst_in_ready", {63'd0, rdy32}, 64'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {63'd0, rdy32}, 64'd1);

        step();
        send1(32'hFFF00093, 3'd0, 8'h01);
        chk("dir_I_valid", {63'd0, vld32}, 64'd1);
        chk("dir_I", {32'd0, imm32}, 64'hFFFF_FFFF);
        step();
        send1(32'hFE000EE3, 3'd2, 8'h02);
        chk("dir_B", {32'd0, imm32}, 64'hFFFF_FFFC);
        step();
        send1(32'h123450B7, 3'd4, 8'h03);
        chk("dir_U", {32'd0, imm32}, 64'h1234_5000);
        step();
        send1(32'h800000B7, 3'd4, 8'h04);
        chk("dir_LUI64", imm64, 64'hFFFF_FFFF_8000_0000);
        step();
        send1(32'h03F00000, 3'd6, 8'h05);
        chk("dir_SHAMT64", imm64, 64'd63);
        step();
        send1(32'h000F8000, 3'd5, 8'h06);
        chk("dir_Z64", imm64, 64'h1F);
        step();
        send1(32'hFFFFFFFF, 3'd7, 8'h5A);
        chk("dir_ill_flag", {63'd0, ill64}, 64'd1);
        chk("dir_ill_imm", imm64, 64'd0);
        chk("dir_ill_tag", {56'd0, tag64}, 64'h5A);
        step();

        // Backpressure: tags 1,2,3 back-to-back with the consumer stalled.
        out_ready = 1'b0;
        drive(32'h00100093, 3'd0, 8'd1); step();
        drive(32'h00200093, 3'd0, 8'd2); step();
        @(negedge clk);
        chk("bp_in_ready_low", {63'd0, rdy32}, 64'd0);
        drive(32'h00300093, 3'd0, 8'd3);
        step(); step();
        @(negedge clk);
        chk("bp_head_tag", {56'd0, tag32}, 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rdy32) begin
                step();
                break;
            end
            step();
        end
        in_valid = 1'b0;
        step(); step(); step();

        // Two more illegals then a reset while FULL.
        send1(32'h0, 3'd7, 8'h11);
        step();
        send1(32'h0, 3'd7, 8'h12);
        step();
        out_ready = 1'b0;
        drive(32'h00500093, 3'd0, 8'h21); step();
        drive(32'h00600093, 3'd0, 8'h22); step();
        in_valid = 1'b0;
        reset = 1'b1;
        drive(32'h00700093, 3'd0, 8'h23);
        @(negedge clk);
        chk("full_rst_in_ready", {63'd0, rdy32}, 64'd0);
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("after_rst_valid", {63'd0, vld32}, 64'd0);
        chk("after_rst_in_ready", {63'd0, rdy32}, 64'd1);
        step();

        // Continuous valid, always-ready consumer.
        for (int k = 0; k < 12; k++) begin
            drive($urandom, 3'($urandom_range(0, 7)), 8'(k));
            step();
        end
        in_valid = 1'b0;

        // Random traffic with occasional reset.
        for (int k = 0; k < 3000; k++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_instr  = 25'($urandom);
            in_immsrc = 3'($urandom_range(0, 7));
            in_tag    = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            reset     = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step(); step(); step();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
